uart_baud_gen: RTL

UART_BAUD_GEN -- requirements
Module: uart_baud_gen

---
 rtl/uart_baud_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional-N UART baud tick generator (rx oversample tick + tx bit tick)
//
// Optional feature macro: UART_BAUD_FRAC_EN (fractional divisor accumulator).
//
// Ports:
//   clk       in   single clock
//   rst       in   asynchronous active-low reset
//   en        in   tick generation enable; low holds the counters at zero
//   resync    in   receiver start-bit realign; zeroes counters, suppresses the tick
//   div_wr    in   divisor write strobe
//   div_int   in   clk cycles per rx tick, integer part (must be >= 2)
//   div_frac  in   fractional part in units of 2^-FRAC_W (ignored without the macro)
//   rx_tick   out  1-cycle pulse at OVERSAMPLE x baud
//   tx_tick   out  1-cycle pulse at baud, coincident with every OVERSAMPLE-th rx_tick
//   div_pend  out  an accepted divisor is waiting for the next period boundary
//   div_err   out  1-cycle pulse after a rejected divisor write
`timescale 1ns/1ps

module uart_baud_gen #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              resync,
    input  logic              div_wr,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              div_pend,
    output logic              div_err
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    localparam longint unsigned CLK_L   = 64'(CLK_HZ);
    localparam longint unsigned TICK_HZ = 64'(BAUD) * 64'(OVERSAMPLE);
    localparam logic [DIV_W-1:0] RST_INT = DIV_W'(CLK_L / TICK_HZ);

    logic [DIV_W-1:0] a_int;
    logic [DIV_W-1:0] p_int;
    logic [DIV_W-1:0] cnt;
    logic [OS_W-1:0]  os;
    logic             carry;
    logic [DIV_W:0]   last;
    logic             wrap;
    logic             wr_ok;
    logic             apply;

`ifdef UART_BAUD_FRAC_EN
    // Fixed-point reset divisor; truncation to FRAC_W bits keeps only the fraction.
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'((CLK_L << FRAC_W) / TICK_HZ);

    logic [FRAC_W-1:0] a_frac;
    logic [FRAC_W-1:0] p_frac;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    // The period is stretched by one cycle whenever the fraction accumulator wraps.
    assign acc_sum = {1'b0, acc} + {1'b0, a_frac};
    assign carry   = acc_sum[FRAC_W];
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^div_frac;
`endif

    // Terminal count P-1, computed one bit wider so P = 2^DIV_W cannot alias.
    assign last  = {1'b0, a_int} + {{DIV_W{1'b0}}, carry} - (DIV_W + 1)'(1);
    assign wrap  = ({1'b0, cnt} == last);
    assign wr_ok = div_wr && (div_int >= DIV_W'(2));
    // A new divisor only takes effect on a period boundary or while counting is
    // stopped, so a period is never cut short or doubled.
    assign apply = div_pend && (!en || resync || wrap);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            os       <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
            div_pend <= 1'b0;
            div_err  <= 1'b0;
            a_int    <= RST_INT;
            p_int    <= '0;
        end else begin
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
            div_err <= div_wr && !wr_ok;

            if (!en || resync) begin
                cnt <= '0;
                os  <= '0;
            end else if (wrap) begin
                cnt     <= '0;
                rx_tick <= 1'b1;
                tx_tick <= (os == OS_LAST);
                os      <= (os == OS_LAST) ? '0 : os + OS_W'(1);
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            if (apply) begin
                a_int <= p_int;
            end
            if (wr_ok) begin
                p_int <= div_int;
            end
            // A write coinciding with an apply becomes the next pending value.
            div_pend <= wr_ok || (div_pend && !apply);
        end
    end

`ifdef UART_BAUD_FRAC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            a_frac <= RST_FRAC;
            p_frac <= '0;
        end else begin
            if (!en || resync || apply) begin
                acc <= '0;
            end else if (wrap) begin
                acc <= acc_sum[FRAC_W-1:0];
            end
            if (apply) begin
                a_frac <= p_frac;
            end
            if (wr_ok) begin
                p_frac <= div_frac;
            end
        end
    end
`endif

endmodule
